// File: rtl/text_pkg.sv
`default_nettype none
// ============================================================================
// Module      : text_pkg
// Description : Shared constants, state encoding and address-width helper
//               for the character-cell text screen writer.
// Revision    : 1.0  initial release
// ============================================================================
package text_pkg;

  // Default grid: 640x480 with an 8x16 font
  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 30;

  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [6:0] ASCII_LF    = 7'h0A;
  localparam logic [6:0] ASCII_CR    = 7'h0D;
  localparam logic [6:0] ASCII_BS    = 7'h08;
  localparam logic [6:0] ASCII_TILDE = 7'h7E;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_LINECLR = 2'd2
  } state_t;

  // Bits needed to address every cell of a cols x rows grid
  function automatic int cell_addr_width(input int cols, input int rows);
    return (cols * rows <= 2) ? 1 : $clog2(cols * rows);
  endfunction

endpackage
`default_nettype wire

// File: rtl/text_ram.sv
`default_nettype none
// ============================================================================
// Module      : text_ram
// Description : Simple dual-port cell store, one write port and one
//               synchronous read port. Read-before-write on an address
//               collision so a same-cycle read returns the old contents.
// Revision    : 1.0  initial release
// ============================================================================
module text_ram
  import text_pkg::*;
#(
  parameter int DEPTH = COLS_DEF * ROWS_DEF,
  parameter int AW    = 12,
  parameter int DW    = 7
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/text_screen_writer.sv
`default_nettype none
// ============================================================================
// Module      : text_screen_writer
// Description : Character-cell screen buffer. Accepts a stream of ASCII
//               codes, writes them at a hardware cursor into a COLS x ROWS
//               grid and serves registered cell reads to the text generator.
//               Optional feature macro: CURSOR_BLINK_EN (blinking cursor).
// Revision    : 1.0  initial release
// ============================================================================
module text_screen_writer
  import text_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
`ifdef CURSOR_BLINK_EN
  ,
  parameter int BLINK_CYCLES = 25_000_000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [6:0] wr_char,
  output logic       wr_ready,
  input  logic       clear,
  input  logic [6:0] rd_col,
  input  logic [4:0] rd_row,
  output logic [6:0] rd_char,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row,
  output logic       cursor_on
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = cell_addr_width(COLS, ROWS);

  state_t        r_state,    w_nxt_state;
  logic [AW-1:0] r_fill,     w_nxt_fill;
  logic [6:0]    r_col,      w_nxt_col;
  logic [4:0]    r_row,      w_nxt_row;
  logic          r_clr_pend, w_nxt_clr_pend;

  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [6:0]    w_wdata;

  logic [AW-1:0] w_cur_addr;
  logic [AW-1:0] w_bs_addr;
  logic [AW-1:0] w_line_addr;
  logic [4:0]    w_row_next_line;
  logic          w_printable;

  logic          w_rd_oob;
  logic [AW-1:0] w_rd_addr;
  logic          r_rd_oob;
  logic          r_rd_vld;
  logic [6:0]    w_ram_q;

  assign w_cur_addr      = AW'(int'(r_row) * COLS + int'(r_col));
  assign w_bs_addr       = AW'(int'(r_row) * COLS + int'(r_col) - 1);
  assign w_line_addr     = AW'(int'(r_row) * COLS + int'(r_fill));
  assign w_row_next_line = (r_row == 5'(ROWS - 1)) ? 5'd0 : r_row + 5'd1;
  assign w_printable     = (wr_char >= ASCII_SPACE) && (wr_char <= ASCII_TILDE);

  // clear has priority over a write offered in the same cycle
  assign wr_ready   = (r_state == ST_IDLE) & ~clear;
  assign cursor_col = r_col;
  assign cursor_row = r_row;

  // State, fill index, cursor and pending-clear registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_CLEAR;
      r_fill     <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_clr_pend <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_fill     <= w_nxt_fill;
      r_col      <= w_nxt_col;
      r_row      <= w_nxt_row;
      r_clr_pend <= w_nxt_clr_pend;
    end
  end

  // Next-state, cursor update and cell write decode
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_fill     = r_fill;
    w_nxt_col      = r_col;
    w_nxt_row      = r_row;
    w_nxt_clr_pend = r_clr_pend;
    w_we           = 1'b0;
    w_waddr        = w_cur_addr;
    w_wdata        = ASCII_SPACE;

    case (r_state)
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_fill;
        if (r_fill == AW'(CELLS - 1)) begin
          w_nxt_state = ST_IDLE;
          w_nxt_fill  = '0;
        end else begin
          w_nxt_fill = r_fill + AW'(1);
        end
      end

      ST_LINECLR: begin
        w_we           = 1'b1;
        w_waddr        = w_line_addr;
        w_nxt_clr_pend = r_clr_pend | clear;
        if (r_fill == AW'(COLS - 1)) begin
          w_nxt_fill = '0;
          if (r_clr_pend | clear) begin
            // A clear seen during the line wipe is honoured now
            w_nxt_state    = ST_CLEAR;
            w_nxt_clr_pend = 1'b0;
            w_nxt_col      = '0;
            w_nxt_row      = '0;
          end else begin
            w_nxt_state = ST_IDLE;
          end
        end else begin
          w_nxt_fill = r_fill + AW'(1);
        end
      end

      ST_IDLE: begin
        if (clear) begin
          w_nxt_state = ST_CLEAR;
          w_nxt_fill  = '0;
          w_nxt_col   = '0;
          w_nxt_row   = '0;
        end else if (wr_valid) begin
          if (w_printable) begin
            w_we    = 1'b1;
            w_wdata = wr_char;
            if (r_col == 7'(COLS - 1)) begin
              w_nxt_col   = '0;
              w_nxt_row   = w_row_next_line;
              w_nxt_state = ST_LINECLR;
              w_nxt_fill  = '0;
            end else begin
              w_nxt_col = r_col + 7'd1;
            end
          end else if ((wr_char == ASCII_LF) || (wr_char == ASCII_CR)) begin
            w_nxt_col   = '0;
            w_nxt_row   = w_row_next_line;
            w_nxt_state = ST_LINECLR;
            w_nxt_fill  = '0;
          end else if (wr_char == ASCII_BS) begin
            if (r_col != 7'd0) begin
              w_nxt_col = r_col - 7'd1;
              w_we      = 1'b1;
              w_waddr   = w_bs_addr;
            end
          end
        end
      end

      default: begin
        w_nxt_state = ST_CLEAR;
        w_nxt_fill  = '0;
      end
    endcase
  end

  // Out-of-range reads are steered to a safe address and forced to space
  assign w_rd_oob  = (int'(rd_col) >= COLS) || (int'(rd_row) >= ROWS);
  assign w_rd_addr = w_rd_oob ? '0 : AW'(int'(rd_row) * COLS + int'(rd_col));

  // Read-side qualifiers aligned with the RAM output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_oob <= 1'b0;
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_oob <= w_rd_oob;
      r_rd_vld <= 1'b1;
    end
  end

  assign rd_char = !r_rd_vld ? 7'd0 : (r_rd_oob ? ASCII_SPACE : w_ram_q);

  text_ram #(
    .DEPTH (CELLS),
    .AW    (AW),
    .DW    (7)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_q)
  );

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic          w_accept;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink;

  assign w_accept = wr_valid & wr_ready;

  // Blink phase: runs only in IDLE, restarts on every accepted code
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (w_accept || (r_state != ST_IDLE)) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  assign cursor_on = r_blink & (r_state == ST_IDLE);
`else
  assign cursor_on = (r_state == ST_IDLE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_text_screen_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_screen_writer
// Description : Self-checking bench for text_screen_writer. Cell reads are
//               queued with their expected code and checked by a monitor
//               one cycle later; cursor and handshake timing checked inline.
// Revision    : 1.0  initial release
// ============================================================================
module tb_text_screen_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic [6:0] wr_char = 7'd0;
  logic       wr_ready;
  logic       clear = 1'b0;
  logic [6:0] rd_col = 7'd0;
  logic [4:0] rd_row = 5'd0;
  logic [6:0] rd_char;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       cursor_on;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [6:0] exp;
    int         col;
    int         row;
  } rd_exp_t;

  rd_exp_t sb[$];
  rd_exp_t mon_e;
  logic    rd_req   = 1'b0;
  logic    r_req_q  = 1'b0;

  always #5 clk = ~clk;

  text_screen_writer dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_char    (wr_char),
    .wr_ready   (wr_ready),
    .clear      (clear),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_char    (rd_char),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .cursor_on  (cursor_on)
  );

  // Read monitor: a request seen at a posedge has its data at the next negedge
  always @(posedge clk) r_req_q <= rd_req;

  always @(negedge clk) begin
    if (r_req_q) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL rd_scoreboard: got rd_char=%h with no expected entry", rd_char);
      end else begin
        mon_e = sb.pop_front();
        if (rd_char === mon_e.exp) n_pass++;
        else $display("FAIL rd_char(%0d,%0d): got %h expected %h",
                      mon_e.col, mon_e.row, rd_char, mon_e.exp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic rd_push(input int col, input int row, input logic [6:0] exp);
    rd_exp_t e;
    @(negedge clk);
    rd_col = 7'(col);
    rd_row = 5'(row);
    e.exp  = exp;
    e.col  = col;
    e.row  = row;
    sb.push_back(e);
    rd_req = 1'b1;
  endtask

  task automatic rd_flush();
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  // Counts negedges until wr_ready is high, starting at the current one
  task automatic wait_ready(output int cnt, input int budget);
    cnt = 0;
    while (!wr_ready && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  // Offers one code and returns at the negedge after it is transferred
  task automatic send(input logic [6:0] c);
    int t;
    t = 0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_char  = c;
    #1;
    while (!wr_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!wr_ready) begin
      n_total++;
      $display("FAIL send_timeout: wr_ready=0 expected 1");
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish expected done");
    $fatal(1);
  end

  initial begin
    int cnt;

    // ---------------- 1) reset and power-on clear ----------------
    repeat (3) @(negedge clk);
    chk("rst_wr_ready",  int'(wr_ready),   0);
    chk("rst_cursor_col", int'(cursor_col), 0);
    chk("rst_cursor_row", int'(cursor_row), 0);
    chk("rst_rd_char",   int'(rd_char),    0);
    chk("rst_cursor_on", int'(cursor_on),  0);
    reset = 1'b0;
    wait_ready(cnt, 3000);
    chk("clear_len", cnt, 2400);
    chk("idle_cursor_on", int'(cursor_on), 1);
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++)
        rd_push(c, r, 7'h20);
    rd_push(80, 0, 7'h20);
    rd_push(0, 30, 7'h20);
    rd_push(127, 31, 7'h20);
    rd_flush();

    // ---------------- 2) "Hi" ----------------
    send(7'h48);
    send(7'h69);
    rd_push(0, 0, 7'h48);
    rd_push(1, 0, 7'h69);
    rd_flush();
    chk("hi_cursor_col", int'(cursor_col), 2);
    chk("hi_cursor_row", int'(cursor_row), 0);

    // ---------------- 3) line wrap after 80 chars ----------------
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    wait_ready(cnt, 3000);
    chk("clr3_len", cnt, 2400);
    chk("clr3_cursor_col", int'(cursor_col), 0);
    for (int i = 0; i < 80; i++) send(7'(7'h41 + i % 26));
    wait_ready(cnt, 200);
    chk("lineclr_len", cnt, 80);
    chk("wrap_cursor_row", int'(cursor_row), 1);
    send(7'h23);
    chk("c81_cursor_col", int'(cursor_col), 1);
    chk("c81_cursor_row", int'(cursor_row), 1);
    rd_push(0, 0, 7'h41);
    rd_push(25, 0, 7'h5A);
    rd_push(79, 0, 7'h42);
    rd_push(0, 1, 7'h23);
    rd_push(1, 1, 7'h20);
    rd_flush();

    // ---------------- 4) newline on last row wraps to row 0 ----------------
    for (int i = 0; i < 28; i++) send(7'h0D);
    chk("r29_cursor_row", int'(cursor_row), 29);
    for (int i = 0; i < 5; i++) send(7'(7'h61 + i));
    chk("r29_cursor_col", int'(cursor_col), 5);
    send(7'h0D);
    wait_ready(cnt, 200);
    chk("wrap0_lineclr_len", cnt, 80);
    chk("wrap0_cursor_col", int'(cursor_col), 0);
    chk("wrap0_cursor_row", int'(cursor_row), 0);
    for (int c = 0; c < 80; c++) rd_push(c, 0, 7'h20);
    rd_push(0, 29, 7'h61);
    rd_push(4, 29, 7'h65);
    rd_flush();

    // ---------------- 5) backspace and ignored codes ----------------
    for (int i = 0; i < 3; i++) send(7'h0A);
    send(7'h08);
    chk("bs0_cursor_col", int'(cursor_col), 0);
    chk("bs0_cursor_row", int'(cursor_row), 3);
    send(7'h77); send(7'h78); send(7'h79); send(7'h7A);
    chk("bs_pre_cursor_col", int'(cursor_col), 4);
    send(7'h08);
    chk("bs_cursor_col", int'(cursor_col), 3);
    chk("bs_cursor_row", int'(cursor_row), 3);
    send(7'h01);
    chk("ctl_cursor_col", int'(cursor_col), 3);
    send(7'h7F);
    chk("del_cursor_col", int'(cursor_col), 3);
    rd_push(3, 3, 7'h20);
    rd_push(2, 3, 7'h79);
    rd_push(0, 3, 7'h77);
    rd_flush();

    // ---------------- 6) clear beats write; reset mid-clear ----------------
    @(negedge clk);
    clear    = 1'b1;
    wr_valid = 1'b1;
    wr_char  = 7'h51;
    #1;
    chk("clr_wr_ready", int'(wr_ready), 0);
    @(negedge clk);
    clear    = 1'b0;
    wr_valid = 1'b0;
    chk("clr_cursor_col", int'(cursor_col), 0);
    chk("clr_cursor_row", int'(cursor_row), 0);
    chk("clr_cursor_on",  int'(cursor_on),  0);
    wait_ready(cnt, 3000);
    chk("clr6_len", cnt, 2400);
    rd_push(0, 0, 7'h20);
    rd_push(2, 3, 7'h20);
    rd_push(4, 29, 7'h20);
    rd_flush();

    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    repeat (1000) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_wr_ready", int'(wr_ready), 0);
    reset = 1'b0;
    wait_ready(cnt, 3000);
    chk("rst_mid_clear_len", cnt, 2400);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
